// File: rtl/fetch_line_buffer.sv
// Single-line instruction fetch buffer: answers word reads from a cached 256-bit line
// and refills that line from physical memory with a four-beat burst on a miss.
module fetch_line_buffer #(
  parameter int width      = 32,
  parameter int beat_width = 64,
  parameter int beats      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic [width-1:0]      mem_address,
  input  logic                  flush,
  output logic                  mem_resp,
  output logic [width-1:0]      mem_rdata,
  output logic                  pmem_read,
  output logic [width-1:0]      pmem_address,
  input  logic [beat_width-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  localparam int line_bytes = (beat_width * beats) / 8;
  localparam int off_w      = $clog2(line_bytes);
  localparam int idx_w      = $clog2(beats);
  localparam int word_w     = $clog2(width / 8);
  localparam int tag_w      = width - off_w;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                state_r, state_s;
  logic                  valid_r, valid_s;
  logic [tag_w-1:0]      tag_r, tag_s;
  logic [idx_w-1:0]      cnt_r, cnt_s;
  logic                  kill_r, kill_s;
  logic                  resp_s;
  logic [width-1:0]      rdata_s;
  logic                  pread_s;
  logic [width-1:0]      paddr_s;
  logic                  line_we_s;
  logic [beat_width-1:0] line_r [beats];

  logic [tag_w-1:0]      req_tag_s;
  logic [idx_w-1:0]      req_beat_s;
  logic                  req_hi_s;
  logic                  hit_s;
  logic                  dead_s;
  logic [beat_width-1:0] fill_beat_s;
  logic                  unused_s;

  function automatic logic [width-1:0] pick_word(input logic [beat_width-1:0] beat,
                                                 input logic hi);
    if (hi) begin
      return beat[width +: width];
    end else begin
      return beat[width-1:0];
    end
  endfunction

  assign req_tag_s  = mem_address[width-1:off_w];
  assign req_beat_s = mem_address[off_w-1 -: idx_w];
  assign req_hi_s   = mem_address[word_w];
  assign hit_s      = valid_r && (tag_r == req_tag_s);
  assign dead_s     = kill_r || flush;
  assign unused_s   = ^mem_address[word_w-1:0];

  // Requested beat during a fill; the beat arriving this cycle is forwarded from the bus
  always_comb begin
    if (req_beat_s == cnt_r) begin
      fill_beat_s = pmem_rdata;
    end else begin
      fill_beat_s = line_r[req_beat_s];
    end
  end

  // Next-state and next-output logic for the IDLE/FILL/RESP controller
  always_comb begin
    state_s   = state_r;
    valid_s   = valid_r;
    tag_s     = tag_r;
    cnt_s     = cnt_r;
    kill_s    = kill_r;
    resp_s    = 1'b0;
    rdata_s   = mem_rdata;
    pread_s   = pmem_read;
    paddr_s   = pmem_address;
    line_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (flush) begin
          valid_s = 1'b0;
        end else if (mem_read && hit_s) begin
          rdata_s = pick_word(line_r[req_beat_s], req_hi_s);
          resp_s  = 1'b1;
          state_s = ST_RESP;
        end else if (mem_read) begin
          paddr_s = {req_tag_s, {off_w{1'b0}}};
          cnt_s   = '0;
          kill_s  = 1'b0;
          valid_s = 1'b0;
          pread_s = 1'b1;
          state_s = ST_FILL;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        // A flush mid-burst cannot stop the arbiter, so it is remembered until the end
        if (flush) begin
          kill_s = 1'b1;
        end else begin
          kill_s = kill_r;
        end
        if (pmem_resp) begin
          line_we_s = 1'b1;
          cnt_s     = cnt_r + idx_w'(1);
          if (cnt_r == idx_w'(beats - 1)) begin
            pread_s = 1'b0;
            tag_s   = pmem_address[width-1:off_w];
            valid_s = !dead_s;
            if (mem_read && !dead_s) begin
              rdata_s = pick_word(fill_beat_s, req_hi_s);
              resp_s  = 1'b1;
              state_s = ST_RESP;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          state_s = ST_FILL;
        end
      end
      ST_RESP: begin
        state_s = ST_IDLE;
        if (flush) begin
          valid_s = 1'b0;
        end else begin
          valid_s = valid_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pread_s = 1'b0;
      end
    endcase
  end

  // Controller state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      valid_r      <= 1'b0;
      tag_r        <= '0;
      cnt_r        <= '0;
      kill_r       <= 1'b0;
      mem_resp     <= 1'b0;
      mem_rdata    <= '0;
      pmem_read    <= 1'b0;
      pmem_address <= '0;
    end else begin
      state_r      <= state_s;
      valid_r      <= valid_s;
      tag_r        <= tag_s;
      cnt_r        <= cnt_s;
      kill_r       <= kill_s;
      mem_resp     <= resp_s;
      mem_rdata    <= rdata_s;
      pmem_read    <= pread_s;
      pmem_address <= paddr_s;
    end
  end

  // Line storage: plain data array, written one beat per accepted pmem_resp
  always_ff @(posedge clk) begin
    if (line_we_s) begin
      line_r[cnt_r] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_fetch_line_buffer.sv
// Self-checking bench for fetch_line_buffer: a cycle-stepped physical-memory model
// plus a scoreboard of expected fetch words.
module tb_fetch_line_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic [31:0] mem_address;
  logic        flush;
  logic        mem_resp;
  logic [31:0] mem_rdata;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;

  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          cyc      = 0;
  int          gap      = 0;
  int          gap_ctr  = 0;
  int          bcnt     = 0;
  int          bursts   = 0;
  int          beats_given = 0;
  int          last_beat_cyc = 0;
  logic        prev_pread = 1'b0;
  logic [31:0] burst_addr = 32'd0;
  logic [31:0] sb_q [$];

  fetch_line_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .flush        (flush),
    .mem_resp     (mem_resp),
    .mem_rdata    (mem_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory contents: line 0x1000 holds the documented pattern, others a derived one
  function automatic logic [31:0] exp_word(input logic [31:0] a);
    logic [31:0] ln;
    logic [31:0] k;
    ln = a & 32'hFFFF_FFE0;
    k  = {29'd0, a[4:2]};
    if (ln == 32'h0000_1000) return 32'h1111_1111 * k;
    else return ln ^ (32'h0101_0101 * (k + 32'd1));
  endfunction

  function automatic logic [63:0] beat_of(input logic [31:0] ln, input int i);
    logic [31:0] base;
    base = (ln & 32'hFFFF_FFE0) + 32'(8 * i);
    return {exp_word(base + 32'd4), exp_word(base)};
  endfunction

  // One cycle: move to the falling edge, observe, and play physical memory
  task automatic step();
    @(negedge clk);
    cyc++;
    if (pmem_read && !prev_pread) begin
      bursts++;
      burst_addr = pmem_address;
    end
    prev_pread = pmem_read;
    if (!pmem_read || rst) begin
      bcnt = 0;
      gap_ctr = gap;
      pmem_resp = 1'b0;
      pmem_rdata = 64'd0;
    end else if (bcnt < 4 && gap_ctr >= gap) begin
      pmem_rdata = beat_of(pmem_address, bcnt);
      pmem_resp = 1'b1;
      bcnt++;
      gap_ctr = 0;
      beats_given++;
      last_beat_cyc = cyc;
    end else begin
      pmem_resp = 1'b0;
      gap_ctr++;
    end
  endtask

  task automatic wait_resp(input int budget, output logic got, output int lat);
    int c0;
    c0 = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      step();
      if (mem_resp) begin
        got = 1'b1;
        lat = cyc - c0;
        break;
      end
    end
    mem_read = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read = 1'b0; mem_address = 32'd0; flush = 1'b0;
    pmem_resp = 1'b0; pmem_rdata = 64'd0;
    step(); step();
    chk_cnt++; if (mem_resp !== 1'b0) $display("FAIL reset_resp: got %b want 0", mem_resp); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", mem_rdata); else pass_cnt++;
    chk_cnt++; if (pmem_read !== 1'b0) $display("FAIL reset_pread: got %b want 0", pmem_read); else pass_cnt++;
    chk_cnt++; if (pmem_address !== 32'd0) $display("FAIL reset_paddr: got %h want 0", pmem_address); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_cold_miss();
    logic got; int lat; int b0; logic [31:0] exp;
    gap = 0; b0 = bursts;
    mem_address = 32'h0000_1004; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_1004));
    wait_resp(40, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (got !== 1'b1) $display("FAIL cold_resp: got %b want 1", got); else pass_cnt++;
    chk_cnt++; if (lat != 5) $display("FAIL cold_latency: got %0d want 5", lat); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL cold_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    chk_cnt++; if (burst_addr !== 32'h0000_1000) $display("FAIL cold_paddr: got %h want 00001000", burst_addr); else pass_cnt++;
    chk_cnt++; if (bursts - b0 != 1) $display("FAIL cold_bursts: got %0d want 1", bursts - b0); else pass_cnt++;
    step();
  endtask

  task automatic test_hits();
    logic [31:0] addrs [3];
    logic got; int lat; int b0; logic [31:0] exp;
    addrs = '{32'h0000_1000, 32'h0000_1008, 32'h0000_101C};
    b0 = bursts;
    for (int i = 0; i < 3; i++) begin
      step();
      mem_address = addrs[i]; mem_read = 1'b1; sb_q.push_back(exp_word(addrs[i]));
      wait_resp(20, got, lat);
      exp = sb_q.pop_front();
      chk_cnt++; if (lat != 1) $display("FAIL hit_latency[%0d]: got %0d want 1", i, lat); else pass_cnt++;
      chk_cnt++; if (mem_rdata !== exp) $display("FAIL hit_data[%0d]: got %h want %h", i, mem_rdata, exp); else pass_cnt++;
    end
    chk_cnt++; if (bursts != b0) $display("FAIL hit_no_refill: got %0d bursts want 0", bursts - b0); else pass_cnt++;
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    int n; int last; logic [31:0] exp;
    addrs = '{32'h0000_1000, 32'h0000_100C, 32'h0000_1014, 32'h0000_1018};
    step();
    n = 0; last = cyc;
    mem_address = addrs[0]; mem_read = 1'b1; sb_q.push_back(exp_word(addrs[0]));
    for (int i = 0; i < 40 && n < 4; i++) begin
      step();
      if (mem_resp) begin
        exp = sb_q.pop_front();
        chk_cnt++; if (mem_rdata !== exp) $display("FAIL b2b_data[%0d]: got %h want %h", n, mem_rdata, exp); else pass_cnt++;
        chk_cnt++; if (cyc - last != ((n == 0) ? 1 : 2)) $display("FAIL b2b_spacing[%0d]: got %0d want %0d", n, cyc - last, (n == 0) ? 1 : 2); else pass_cnt++;
        last = cyc; n++;
        if (n < 4) begin
          mem_address = addrs[n]; sb_q.push_back(exp_word(addrs[n]));
        end else begin
          mem_read = 1'b0;
        end
      end
    end
    mem_read = 1'b0;
    chk_cnt++; if (n != 4) $display("FAIL b2b_count: got %0d want 4", n); else pass_cnt++;
    step();
  endtask

  task automatic test_flush_idle();
    logic got; int lat; int b0; logic [31:0] exp;
    gap = 0; b0 = bursts;
    step();
    flush = 1'b1; mem_address = 32'h0000_1000; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_1000));
    step();
    flush = 1'b0;
    chk_cnt++; if (mem_resp !== 1'b0) $display("FAIL flush_no_resp: got %b want 0", mem_resp); else pass_cnt++;
    wait_resp(40, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (lat != 5) $display("FAIL flush_refill_latency: got %0d want 5", lat); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL flush_refill_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    chk_cnt++; if (bursts - b0 != 1) $display("FAIL flush_refill_bursts: got %0d want 1", bursts - b0); else pass_cnt++;
    step();
  endtask

  task automatic test_stall();
    logic got; int lat; logic [31:0] exp;
    gap = 2;
    step();
    mem_address = 32'h0000_2010; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_2010));
    wait_resp(60, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (lat != 11) $display("FAIL stall_latency: got %0d want 11", lat); else pass_cnt++;
    chk_cnt++; if (cyc != last_beat_cyc + 1) $display("FAIL stall_resp_after_beat3: got %0d want %0d", cyc, last_beat_cyc + 1); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL stall_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    gap = 0;
    for (int i = 0; i < 2; i++) begin
      step();
      mem_address = (i == 0) ? 32'h0000_2000 : 32'h0000_201C; mem_read = 1'b1;
      sb_q.push_back(exp_word(mem_address));
      wait_resp(20, got, lat);
      exp = sb_q.pop_front();
      chk_cnt++; if (lat != 1 || mem_rdata !== exp) $display("FAIL stall_line_hit[%0d]: got %h lat %0d want %h lat 1", i, mem_rdata, lat, exp); else pass_cnt++;
    end
    step();
  endtask

  task automatic test_flush_fill();
    logic got; int lat; int b0; logic [31:0] exp;
    gap = 1; b0 = bursts;
    step();
    mem_address = 32'h0000_3010; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_3010));
    step(); step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_resp(60, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (bursts - b0 != 2) $display("FAIL flush_fill_remiss: got %0d bursts want 2", bursts - b0); else pass_cnt++;
    chk_cnt++; if (lat != 13) $display("FAIL flush_fill_latency: got %0d want 13", lat); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL flush_fill_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    gap = 0;
    step();
  endtask

  task automatic test_withdrawn();
    logic got; int lat; int b0; int g0; int resps; logic [31:0] exp;
    gap = 0; g0 = beats_given;
    step();
    mem_address = 32'h0000_1000; mem_read = 1'b1;
    step(); step();
    mem_read = 1'b0;
    resps = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_resp) resps++;
    end
    chk_cnt++; if (resps != 0) $display("FAIL withdrawn_no_resp: got %0d want 0", resps); else pass_cnt++;
    chk_cnt++; if (beats_given - g0 != 4 || pmem_read !== 1'b0) $display("FAIL withdrawn_burst_done: got %0d beats pread %b want 4 beats pread 0", beats_given - g0, pmem_read); else pass_cnt++;
    b0 = bursts;
    mem_address = 32'h0000_1004; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_1004));
    wait_resp(20, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (lat != 1 || bursts != b0) $display("FAIL withdrawn_hit: got lat %0d bursts %0d want lat 1 bursts 0", lat, bursts - b0); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL withdrawn_hit_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_fill();
    logic got; int lat; logic [31:0] exp;
    gap = 0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    mem_address = 32'h0000_1000; mem_read = 1'b1;
    step(); step(); step();
    rst = 1'b1; pmem_resp = 1'b0;
    #1;
    chk_cnt++; if (pmem_read !== 1'b0) $display("FAIL midfill_reset_pread: got %b want 0", pmem_read); else pass_cnt++;
    chk_cnt++; if (mem_resp !== 1'b0) $display("FAIL midfill_reset_resp: got %b want 0", mem_resp); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== 32'd0) $display("FAIL midfill_reset_rdata: got %h want 0", mem_rdata); else pass_cnt++;
    mem_read = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    mem_address = 32'h0000_1004; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_1004));
    wait_resp(40, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (lat != 5 || burst_addr !== 32'h0000_1000) $display("FAIL midfill_refill: got lat %0d addr %h want lat 5 addr 00001000", lat, burst_addr); else pass_cnt++;
    chk_cnt++; if (mem_rdata !== exp) $display("FAIL midfill_refill_data: got %h want %h", mem_rdata, exp); else pass_cnt++;
    step();
    mem_address = 32'h0000_1018; mem_read = 1'b1; sb_q.push_back(exp_word(32'h0000_1018));
    wait_resp(20, got, lat);
    exp = sb_q.pop_front();
    chk_cnt++; if (lat != 1 || mem_rdata !== exp) $display("FAIL midfill_beat3_hit: got %h lat %0d want %h lat 1", mem_rdata, lat, exp); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hits();
    test_back_to_back();
    test_flush_idle();
    test_stall();
    test_flush_fill();
    test_withdrawn();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
